// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory responder: 32-bit word accesses served as two
// halfword phases against a 16-bit asynchronous SRAM, freezing the pipeline.
module sram_mem_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   inout  wire  [15:0]        sram_dq,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
   localparam int WW = SRAM_AW - 1;

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          op_wr, op_n;
   logic [WW-1:0] word, word_n;
   logic [31:0]   wdata, wdata_n;
   logic [31:0]   offset;
   logic          req, last;
   logic          phase_n, hi_n;
   logic          dq_oe;
   logic [15:0]   dq_out;
   logic          unused_addr;

   assign offset      = address - 32'(BASE_ADDR);
   assign unused_addr = ^{offset[31:SRAM_AW+1], offset[1:0]};
   assign req         = rd_en | wr_en;
   assign last        = (cnt == LAST);

   assign ready = ~rst
                | (state == DONE)
                | ((state == IDLE) & ~req);

   assign sram_dq = dq_oe ? dq_out : 16'bz;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (req) begin
               state_n = LO;
               cnt_n   = '0;
            end
         end
         LO: begin
            if (last) begin
               state_n = HI;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         HI: begin
            if (last) begin
               state_n = DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   // write wins when both enables are set
   always_comb begin
      op_n    = op_wr;
      word_n  = word;
      wdata_n = wdata;
      if ((state == IDLE) && req) begin
         op_n    = wr_en;
         word_n  = offset[SRAM_AW:2];
         wdata_n = write_data;
      end
   end

   assign phase_n = (state_n == LO) | (state_n == HI);
   assign hi_n    = (state_n == HI);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         op_wr <= 1'b0;
         word  <= '0;
         wdata <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         op_wr <= op_n;
         word  <= word_n;
         wdata <= wdata_n;
      end
   end

   // SRAM strobes come straight from flops so the async part sees no glitches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_we_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_addr <= '0;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         sram_we_n <= ~(phase_n & op_n & (cnt_n < LAST));
         sram_oe_n <= ~(phase_n & ~op_n);
         dq_oe     <= phase_n & op_n;
         dq_out    <= hi_n ? wdata_n[31:16] : wdata_n[15:0];
         if (phase_n)
            sram_addr <= {word_n, hi_n};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data <= '0;
      end else if (!op_wr && last) begin
         if (state == LO)
            read_data[15:0] <= sram_dq;
         else if (state == HI)
            read_data[31:16] <= sram_dq;
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a behavioural
// asynchronous SRAM model on the halfword bus.
module tb_sram_mem_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n;
   logic        sram_oe_n;

   logic [15:0] mem [0:63];
   logic [17:0] last_waddr;
   int          n_vec = 0;
   int          n_err = 0;
   int          lowcnt, wecnt, oecnt;
   logic [31:0] rdata;
   logic        got;

   always #5 clk = ~clk;

   sram_mem_controller dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_dq    (sram_dq),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n)
   );

   assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'bz;

   always @(posedge clk)
      if (!sram_we_n)
         mem[sram_addr[5:0]] <= sram_dq;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rst) begin
         chk("bus_excl", 32'(!sram_oe_n && !sram_we_n), 32'd0);
         if (!sram_we_n)
            last_waddr <= sram_addr;
      end

   task automatic access(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
      rd_en      = r;
      wr_en      = w;
      address    = a;
      write_data = d;
      lowcnt = 0;
      wecnt  = 0;
      oecnt  = 0;
      got    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) begin
            got = 1'b1;
            break;
         end
         lowcnt++;
         if (!sram_we_n) wecnt++;
         if (!sram_oe_n) oecnt++;
      end
      rdata = read_data;
      chk("done_seen", 32'(got), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en = 1'b0;
      wr_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      address    = '0;
      write_data = '0;
      last_waddr = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
      chk("t1_low", 32'(lowcnt), 32'd5);
      chk("t1_we", 32'(wecnt), 32'd2);
      chk("t1_oe", 32'(oecnt), 32'd0);
      chk("t1_m0", 32'(mem[0]), 32'h0000BEEF);
      chk("t1_m1", 32'(mem[1]), 32'h0000DEAD);
      idle();

      access(1'b1, 1'b0, 32'd1024, 32'd0);
      chk("t2_rdata", rdata, 32'hDEADBEEF);
      chk("t2_low", 32'(lowcnt), 32'd5);
      chk("t2_oe", 32'(oecnt), 32'd4);
      chk("t2_we", 32'(wecnt), 32'd0);
      idle();

      access(1'b0, 1'b1, 32'd1028, 32'h12345678);
      chk("t3_m2", 32'(mem[2]), 32'h00005678);
      chk("t3_m3", 32'(mem[3]), 32'h00001234);
      idle();
      access(1'b1, 1'b0, 32'd1024, 32'd0);
      chk("t3_rdata", rdata, 32'hDEADBEEF);
      idle();

      access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
      chk("t4_oe", 32'(oecnt), 32'd0);
      chk("t4_keep", rdata, 32'hDEADBEEF);
      chk("t4_m4", 32'(mem[4]), 32'h00005A5A);
      chk("t4_m5", 32'(mem[5]), 32'h0000A5A5);
      idle();
      access(1'b1, 1'b0, 32'd1032, 32'd0);
      chk("t4_rdata", rdata, 32'hA5A55A5A);
      idle();

      wr_en      = 1'b1;
      address    = 32'd1036;
      write_data = 32'hCAFEF00D;
      repeat (4) @(negedge clk);
      chk("t5_inhi", 32'(ready), 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("t5_we_n", 32'(sram_we_n), 32'd1);
      chk("t5_oe_n", 32'(sram_oe_n), 32'd1);
      chk("t5_ready", 32'(ready), 32'd1);
      chk("t5_addr", 32'(sram_addr), 32'd0);
      chk("t5_rdata0", read_data, 32'd0);
      wr_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      access(1'b1, 1'b0, 32'd1024, 32'd0);
      chk("t5_low", 32'(lowcnt), 32'd5);
      chk("t5_rdata", rdata, 32'hDEADBEEF);
      idle();

      access(1'b1, 1'b0, 32'd1028, 32'd0);
      chk("t6a_low", 32'(lowcnt), 32'd5);
      chk("t6a_rdata", rdata, 32'h12345678);
      access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D);
      chk("t6b_low", 32'(lowcnt), 32'd5);
      chk("t6b_keep", rdata, 32'h12345678);
      access(1'b1, 1'b0, 32'd1040, 32'd0);
      chk("t6c_low", 32'(lowcnt), 32'd5);
      chk("t6c_rdata", rdata, 32'h0BADF00D);
      idle();

      access(1'b0, 1'b1, 32'd1020, 32'h77778888);
      chk("wrap_lo_addr", 32'(last_waddr), 32'h0003FFFF);
      chk("wrap_lo_m62", 32'(mem[62]), 32'h00008888);
      chk("wrap_lo_m63", 32'(mem[63]), 32'h00007777);
      idle();
      access(1'b0, 1'b1, 32'd1024 + 32'h00080000 + 32'd24, 32'h33334444);
      chk("wrap_hi_addr", 32'(last_waddr), 32'd13);
      chk("wrap_hi_m12", 32'(mem[12]), 32'h00004444);
      chk("wrap_hi_m13", 32'(mem[13]), 32'h00003333);
      idle();
      access(1'b1, 1'b0, 32'd1027, 32'd0);
      chk("lsb_ignore", rdata, 32'hDEADBEEF);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
